// File: rtl/pwm_breather_if.sv
// Signal bundle for pwm_breather: counter/heartbeat/mode inputs and PWM status outputs.
// The master modport is the driving side; the slave modport is the breather itself.
interface pwm_breather_if #(
  parameter int CNT_W = 20,
  parameter int PWM_W = 8
);
  logic             enable;
  logic [CNT_W-1:0] cnt_in;
  logic             hearth_beat;
  logic             mode_manual;
  logic [PWM_W-1:0] duty_manual;
  logic             pwm_out;
  logic [PWM_W-1:0] duty_cur;
  logic [1:0]       phase;
  logic             period_start;

  modport master (
    output enable, cnt_in, hearth_beat, mode_manual, duty_manual,
    input  pwm_out, duty_cur, phase, period_start
  );

  modport slave (
    input  enable, cnt_in, hearth_beat, mode_manual, duty_manual,
    output pwm_out, duty_cur, phase, period_start
  );
endinterface

// File: rtl/pwm_breather.sv
// LED PWM with period-buffered duty and a heartbeat-stepped breathing fade (up, hold, down, hold).
// Optional macro PWM_BREATHER_GAMMA_EN applies a square-law curve to the fade duty.
module pwm_breather #(
  parameter int CNT_W      = 20,
  parameter int PWM_W      = 8,
  parameter int STEP       = 1,
  parameter int HOLD_STEPS = 4
) (
  input  logic          clk,
  input  logic          reset,
  pwm_breather_if.slave bus
);
  localparam int               HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_W-1:0] MAX       = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] STEP_V    = PWM_W'(STEP);
  localparam logic [PWM_W-1:0] UP_LIMIT  = MAX - STEP_V;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    UP      = 2'b00,
    HOLD_HI = 2'b01,
    DOWN    = 2'b10,
    HOLD_LO = 2'b11
  } phase_t;

  phase_t             r_phase;
  logic               r_hb_q;
  logic               r_pwm;
  logic               r_period_start;
  logic [PWM_W-1:0]   r_duty_active;
  logic [PWM_W-1:0]   r_duty_target;
  logic [HOLD_W-1:0]  r_hold_cnt;

  logic [PWM_W-1:0]   w_cnt_lo;
  logic [PWM_W-1:0]   w_load;
  logic               w_step;
  logic               w_cnt_zero;

  assign w_cnt_lo   = bus.cnt_in[PWM_W-1:0];
  assign w_cnt_zero = (w_cnt_lo == '0);
  assign w_step     = bus.enable & ~bus.mode_manual & bus.hearth_beat & ~r_hb_q;

`ifdef PWM_BREATHER_GAMMA_EN
  logic [2*PWM_W-1:0] w_sq;
  assign w_sq   = {{PWM_W{1'b0}}, r_duty_target} * {{PWM_W{1'b0}}, r_duty_target};
  assign w_load = bus.mode_manual ? bus.duty_manual : w_sq[2*PWM_W-1:PWM_W];
`else
  assign w_load = bus.mode_manual ? bus.duty_manual : r_duty_target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_duty_active  <= '0;
      r_duty_target  <= '0;
      r_phase        <= UP;
      r_hold_cnt     <= '0;
      r_hb_q         <= 1'b1;   // a heartbeat high across reset release must not step
    end else begin
      r_hb_q <= bus.hearth_beat;

      // Duty only changes at the period boundary, so the pulse never glitches.
      if (!bus.enable) begin
        r_pwm          <= 1'b0;
        r_period_start <= 1'b0;
      end else begin
        r_period_start <= w_cnt_zero;
        if (w_cnt_zero) begin
          r_duty_active <= w_load;
          r_pwm         <= (w_load != '0);
        end else begin
          r_pwm <= (w_cnt_lo < r_duty_active);
        end
      end

      if (w_step) begin
        unique case (r_phase)
          UP: begin
            if (r_duty_target >= UP_LIMIT) begin
              r_duty_target <= MAX;
              r_hold_cnt    <= '0;
              r_phase       <= HOLD_HI;
            end else begin
              r_duty_target <= r_duty_target + STEP_V;
            end
          end
          HOLD_HI: begin
            if (r_hold_cnt == HOLD_LAST) r_phase <= DOWN;
            else                         r_hold_cnt <= r_hold_cnt + 1'b1;
          end
          DOWN: begin
            if (r_duty_target <= STEP_V) begin
              r_duty_target <= '0;
              r_hold_cnt    <= '0;
              r_phase       <= HOLD_LO;
            end else begin
              r_duty_target <= r_duty_target - STEP_V;
            end
          end
          HOLD_LO: begin
            if (r_hold_cnt == HOLD_LAST) r_phase <= UP;
            else                         r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.pwm_out      = r_pwm;
  assign bus.duty_cur     = r_duty_active;
  assign bus.phase        = r_phase;
  assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_pwm_breather.sv
// Directed bench: an 8-bit manual-mode instance for period/duty behaviour and a
// 4-bit auto-mode instance (STEP=4, HOLD_STEPS=2) for the fade state machine.
module tb_pwm_breather;
  logic clk = 1'b0;
  logic reset8;
  logic reset4;
  int   errors = 0;
  int   checks = 0;
  logic [19:0] cnt8 = '0;

  always #5 clk = ~clk;

  pwm_breather_if #(.CNT_W(20), .PWM_W(8)) b8 ();
  pwm_breather_if #(.CNT_W(8),  .PWM_W(4)) b4 ();

  pwm_breather #(.CNT_W(20), .PWM_W(8), .STEP(1), .HOLD_STEPS(4)) u8 (
    .clk(clk), .reset(reset8), .bus(b8)
  );
  pwm_breather #(.CNT_W(8), .PWM_W(4), .STEP(4), .HOLD_STEPS(2)) u4 (
    .clk(clk), .reset(reset4), .bus(b4)
  );

  // Duty the 4-bit fade instance should report for a given fade target.
  function automatic logic [3:0] exp4(input int t);
`ifdef PWM_BREATHER_GAMMA_EN
    return 4'((t * t) >> 4);
`else
    return 4'(t);
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hb_pulse(input bit wide);
    if (wide) b8.hearth_beat = 1'b1; else b4.hearth_beat = 1'b1;
    cycle();
    if (wide) b8.hearth_beat = 1'b0; else b4.hearth_beat = 1'b0;
    cycle();
  endtask

  task automatic run_period8(input int chg_at, input logic [7:0] chg_val,
                             output int highs, output int ps,
                             output logic first_pwm, output logic [7:0] first_duty);
    highs = 0; ps = 0; first_pwm = 1'b0; first_duty = '0;
    for (int c = 0; c < 256; c++) begin
      if (c == chg_at) b8.duty_manual = chg_val;
      b8.cnt_in = cnt8;
      cycle();
      cnt8 = cnt8 + 20'd1;
      if (b8.pwm_out) highs++;
      if (b8.period_start) ps++;
      if (c == 0) begin
        first_pwm  = b8.pwm_out;
        first_duty = b8.duty_cur;
      end
    end
  endtask

  task automatic test_reset();
    reset8 = 1'b1; reset4 = 1'b1;
    b8.enable = 1'b1; b8.cnt_in = '0; b8.hearth_beat = 1'b0;
    b8.mode_manual = 1'b1; b8.duty_manual = 8'd64;
    b4.enable = 1'b1; b4.cnt_in = '0; b4.hearth_beat = 1'b1;
    b4.mode_manual = 1'b0; b4.duty_manual = '0;
    cycle(); cycle();
    checks++; if (b8.pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", b8.pwm_out); end
    checks++; if (b8.duty_cur !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", b8.duty_cur); end
    checks++; if (b8.phase !== 2'b00) begin errors++; $display("FAIL reset_phase: got %b expected 00", b8.phase); end
    checks++; if (b8.period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", b8.period_start); end
  endtask

  task automatic test_manual();
    int highs, ps; logic fp; logic [7:0] fd;
    reset8 = 1'b0;
    run_period8(-1, 8'd0, highs, ps, fp, fd);
    $display("manual duty=64: highs=%0d period_starts=%0d first_pwm=%b", highs, ps, fp);
    checks++; if (highs !== 64) begin errors++; $display("FAIL manual64_highs: got %0d expected 64", highs); end
    checks++; if (ps !== 1) begin errors++; $display("FAIL manual64_period_start: got %0d expected 1", ps); end
    checks++; if (fp !== 1'b1) begin errors++; $display("FAIL manual64_first_pwm: got %b expected 1", fp); end
    checks++; if (fd !== 8'd64) begin errors++; $display("FAIL manual64_duty_cur: got %0d expected 64", fd); end

    run_period8(100, 8'd192, highs, ps, fp, fd);
    $display("manual change 64->192 at 100: highs=%0d duty_cur=%0d", highs, b8.duty_cur);
    checks++; if (highs !== 64) begin errors++; $display("FAIL midchange_highs: got %0d expected 64", highs); end
    checks++; if (b8.duty_cur !== 8'd64) begin errors++; $display("FAIL midchange_duty_held: got %0d expected 64", b8.duty_cur); end

    run_period8(-1, 8'd0, highs, ps, fp, fd);
    $display("manual duty=192: highs=%0d first_duty=%0d", highs, fd);
    checks++; if (fd !== 8'd192) begin errors++; $display("FAIL boundary_duty_cur: got %0d expected 192", fd); end
    checks++; if (highs !== 192) begin errors++; $display("FAIL manual192_highs: got %0d expected 192", highs); end
  endtask

  task automatic test_endpoints();
    int highs, ps; logic fp; logic [7:0] fd;
    b8.duty_manual = 8'd0;
    run_period8(-1, 8'd0, highs, ps, fp, fd);  // loads 0 at this period's start
    run_period8(-1, 8'd0, highs, ps, fp, fd);
    $display("manual duty=0: highs=%0d", highs);
    checks++; if (highs !== 0) begin errors++; $display("FAIL duty0_highs: got %0d expected 0", highs); end
    b8.duty_manual = 8'd255;
    run_period8(-1, 8'd0, highs, ps, fp, fd);
    $display("manual duty=255: highs=%0d period_starts=%0d", highs, ps);
    checks++; if (highs !== 255) begin errors++; $display("FAIL duty255_highs: got %0d expected 255", highs); end
    checks++; if (ps !== 1) begin errors++; $display("FAIL duty255_period_start: got %0d expected 1", ps); end
  endtask

  task automatic test_hb_reset();
    reset4 = 1'b0;  // heartbeat still high from reset
    cycle(); cycle(); cycle();
    $display("hb held across reset: duty_cur=%0d phase=%b", b4.duty_cur, b4.phase);
    checks++; if (b4.duty_cur !== 4'd0) begin errors++; $display("FAIL hb_reset_duty: got %0d expected 0", b4.duty_cur); end
    checks++; if (b4.phase !== 2'b00) begin errors++; $display("FAIL hb_reset_phase: got %b expected 00", b4.phase); end
    b4.hearth_beat = 1'b0;
    cycle();
  endtask

  task automatic test_fade();
    int tgt [12] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0};
    logic [1:0] ph [12] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                            2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    for (int i = 0; i < 12; i++) begin
      hb_pulse(1'b0);
      $display("fade edge %0d: duty_cur=%0d phase=%b", i + 1, b4.duty_cur, b4.phase);
      checks++; if (b4.duty_cur !== exp4(tgt[i])) begin errors++; $display("FAIL fade_duty_%0d: got %0d expected %0d", i + 1, b4.duty_cur, exp4(tgt[i])); end
      checks++; if (b4.phase !== ph[i]) begin errors++; $display("FAIL fade_phase_%0d: got %b expected %b", i + 1, b4.phase, ph[i]); end
    end
  endtask

  task automatic test_enable();
    hb_pulse(1'b0);  // target 4, phase UP
    b4.enable = 1'b0;
    for (int i = 0; i < 3; i++) hb_pulse(1'b0);
    $display("disabled: pwm=%b duty_cur=%0d phase=%b ps=%b", b4.pwm_out, b4.duty_cur, b4.phase, b4.period_start);
    checks++; if (b4.pwm_out !== 1'b0) begin errors++; $display("FAIL disable_pwm: got %b expected 0", b4.pwm_out); end
    checks++; if (b4.period_start !== 1'b0) begin errors++; $display("FAIL disable_period_start: got %b expected 0", b4.period_start); end
    checks++; if (b4.duty_cur !== exp4(4)) begin errors++; $display("FAIL disable_duty: got %0d expected %0d", b4.duty_cur, exp4(4)); end
    checks++; if (b4.phase !== 2'b00) begin errors++; $display("FAIL disable_phase: got %b expected 00", b4.phase); end
    b4.enable = 1'b1;
    cycle();
    $display("re-enabled: pwm=%b duty_cur=%0d", b4.pwm_out, b4.duty_cur);
    checks++; if (b4.pwm_out !== (exp4(4) != 4'd0)) begin errors++; $display("FAIL reenable_pwm: got %b expected %b", b4.pwm_out, exp4(4) != 4'd0); end
    hb_pulse(1'b0);
    $display("re-enabled step: duty_cur=%0d", b4.duty_cur);
    checks++; if (b4.duty_cur !== exp4(8)) begin errors++; $display("FAIL reenable_step_duty: got %0d expected %0d", b4.duty_cur, exp4(8)); end
  endtask

`ifdef PWM_BREATHER_GAMMA_EN
  task automatic test_gamma();
    b8.mode_manual = 1'b0;
    b8.cnt_in = '0;
    for (int i = 0; i < 128; i++) hb_pulse(1'b1);
    $display("gamma target=128: duty_cur=%0d", b8.duty_cur);
    checks++; if (b8.duty_cur !== 8'd64) begin errors++; $display("FAIL gamma_128: got %0d expected 64", b8.duty_cur); end
    for (int i = 0; i < 127; i++) hb_pulse(1'b1);
    $display("gamma target=255: duty_cur=%0d", b8.duty_cur);
    checks++; if (b8.duty_cur !== 8'd254) begin errors++; $display("FAIL gamma_255: got %0d expected 254", b8.duty_cur); end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_endpoints();
    test_hb_reset();
    test_fade();
    test_enable();
`ifdef PWM_BREATHER_GAMMA_EN
    test_gamma();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_breather.md
Name: pwm_breather

Overview:
- Downstream consumer of the free-running up counter in the PWM/LED datapath.
- Compares the counter's low bits against a glitch-free, period-buffered duty value and drives an LED PWM pin.
- Uses the counter's slow heartbeat bit as a step tick for a breathing fade state machine (ramp up, hold, ramp down, hold).
- A manual mode bypasses the fade and takes a duty value directly.

Parameters:
- CNT_W, 20, width of the counter input.
- PWM_W, 8, number of low counter bits forming one PWM period; MAX = 2^PWM_W-1.
- STEP, 1, duty increment/decrement per heartbeat edge; legal range 1..MAX.
- HOLD_STEPS, 4, heartbeat edges spent at each extreme; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable.
- cnt_in  in  CNT_W  counter value; only bits [PWM_W-1:0] (cnt_lo) are used.
- hearth_beat  in  1  slow tick from counter MSB.
- mode_manual  in  1  1 = duty taken from duty_manual, fade FSM frozen.
- duty_manual  in  PWM_W  manual duty value.
- pwm_out  out  1  registered PWM output.
- duty_cur  out  PWM_W  duty currently applied (duty_active).
- phase  out  2  FSM state: 00 UP, 01 HOLD_HI, 10 DOWN, 11 HOLD_LO.
- period_start  out  1  one-cycle pulse, registered, asserted the cycle after cnt_lo==0 is sampled with enable=1.

Behaviour:
- Reset (clk edge with reset=1):
  - pwm_out=0, duty_active=0, duty_target=0, phase=UP, hold_cnt=0, period_start=0.
  - hb_q=1, so a heartbeat held high across reset release creates no step.
- Edge detect:
  - hb_q <= hearth_beat every cycle, regardless of enable.
  - step = enable & ~mode_manual & hearth_beat & ~hb_q.
- Duty source: src = mode_manual ? duty_manual : duty_target.
- Shadow load, when enable=1 and cnt_lo==0:
  - duty_active <= src.
  - pwm_out <= (src != 0).
- Otherwise, when enable=1: pwm_out <= (cnt_lo < duty_active).
- Latency: pwm_out lags cnt_in by 1 cycle.
- Duty endpoints:
  - duty 0 gives a constant low output.
  - duty MAX gives high for MAX of 2^PWM_W cycles.
  - Full-on is not reachable, by design.
- Mid-period changes to src take effect only at the next cnt_lo==0.
- enable=0:
  - pwm_out <= 0 and period_start <= 0.
  - duty_active, duty_target, phase and hold_cnt hold their values.
  - Heartbeat edges are ignored.
- FSM, advancing only on step:
  - UP: if duty_target >= MAX-STEP, set duty_target<=MAX, hold_cnt<=0, go to HOLD_HI; else duty_target += STEP.
  - HOLD_HI: if hold_cnt==HOLD_STEPS-1, go to DOWN; else hold_cnt++.
  - DOWN: if duty_target <= STEP, set duty_target<=0, hold_cnt<=0, go to HOLD_LO; else duty_target -= STEP.
  - HOLD_LO: if hold_cnt==HOLD_STEPS-1, go to UP; else hold_cnt++.
- Arithmetic saturates and never wraps; all comparisons are unsigned; hold_cnt is sized for HOLD_STEPS-1.
- Leaving manual mode resumes the fade from the held phase/duty_target; the new source applies at the next period start.
- A cnt_in discontinuity (counter reset) is tolerated: the next cnt_lo==0 reloads duty_active.
- Reset mid-period overrides everything on that edge.

Optional Feature:
- Macro: PWM_BREATHER_GAMMA_EN.
- When defined, the FSM path (mode_manual=0) loads duty_active with (duty_target*duty_target)>>PWM_W at period start. This gives a perceptual (square-law) fade. Manual mode stays linear. duty_cur reports the post-gamma value.
- When undefined: linear load, and no multiplier is synthesised.

Test Plan:
- Manual mode, duty_manual=64, cnt_in incrementing from 0 -> pwm_out high exactly 64 of every 256 cycles, rising one cycle after cnt_lo=0; period_start pulses every 256 cycles.
- duty_manual changed 64->192 at cnt_lo=100 -> that period still has 64 high cycles; the next period has 192; duty_cur changes exactly at the boundary.
- duty_manual=0 -> pwm_out never high; duty_manual=255 -> 255 high cycles per period.
- PWM_W=4, STEP=4, HOLD_STEPS=2, auto mode, heartbeat edges ->
  - duty_target 4,8,12,15, then phase HOLD_HI;
  - two edges later phase DOWN;
  - then 11,7,3,0, phase HOLD_LO;
  - two edges later phase UP.
- hearth_beat=1 across reset release -> no step until a genuine 0->1 edge. enable=0 for 3 heartbeat edges -> pwm_out=0 and phase/duty_target unchanged; on re-enable the output resumes at the next period start.
- With PWM_BREATHER_GAMMA_EN, PWM_W=8, duty_target=128 -> duty_cur=64 after the next period start; duty_target=255 -> duty_cur=254.
